kbd_scan_decoder: RTL and testbench
===================================

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8: width of the key-press counter.
REQ-002 The block SHALL have parameter FILTER_REPEAT, default 1: 1 suppresses typematic repeats of the held key.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ready  input  1  PS/2 receiver FIFO non-empty; data is valid.
REQ-006 data  input  8  PS/2 receiver FIFO head byte.
REQ-007 overflow  input  1  PS/2 receiver FIFO overflow indication.
REQ-008 nextdata_n  output  1  registered active-low pop strobe to the receiver.
REQ-009 evt_valid  output  1  one-cycle pulse marking a decoded key event.
REQ-010 evt_make  output  1  1 = press, 0 = release; valid with evt_valid.
REQ-011 key_code  output  8  last make code, held.
REQ-012 key_ext  output  1  last make code carried an E0 prefix.
REQ-013 key_ascii  output  8  lowercase ASCII of key_code; 0x00 if unmapped or extended.
REQ-014 key_down  output  1  a key is currently held.
REQ-015 press_cnt  output  COUNT_W  count of accepted presses.
REQ-016 err_ovf  output  1  sticky flag, set when overflow is seen high.

Function
REQ-017 Pop handshake SHALL use three states: FETCH, POP, GAP.
- FETCH: on ready=1, capture data; nextdata_n=0 during the next cycle (POP).
- POP -> GAP: nextdata_n returns to 1.
- GAP: no sampling of ready, so the receiver pointer can settle.
- GAP -> FETCH.
- Result: one byte consumed per pop; at most one pop per 3 cycles.
REQ-018 Parse FSM SHALL have states P_IDLE, P_BRK, P_EXT, P_EXT_BRK, advancing once per captured byte.
REQ-019 In P_IDLE, the byte SHALL be handled as follows:
- 0xE0 -> P_EXT.
- 0xF0 -> P_BRK.
- any other byte is a make code; stay in P_IDLE.
REQ-020 In P_EXT, 0xF0 SHALL go to P_EXT_BRK; any other byte is an extended make, then -> P_IDLE.
REQ-021 In P_BRK or P_EXT_BRK, the byte SHALL be a break code (extended in P_EXT_BRK), then -> P_IDLE.
REQ-022 An 0xE0 byte received in P_BRK, P_EXT or P_EXT_BRK SHALL be discarded, with the FSM -> P_EXT.
REQ-023 A make event SHALL be generated in the cycle after capture:
- key_code, key_ext, key_ascii updated.
- key_down=1.
- evt_valid=1, evt_make=1.
- press_cnt +1, wrapping from all-ones to 0.
REQ-024 When FILTER_REPEAT=1, a make equal to the held key (key_down=1 and same code and same ext) SHALL produce no event and no count.
REQ-025 A break matching the held code and ext SHALL clear key_down and pulse evt_valid with evt_make=0; key_code is held.
REQ-026 A non-matching break SHALL be consumed with no event and no state change.
REQ-027 key_ascii mapping SHALL be scan-code set 2: a-z, 0-9, space (0x29); all other codes -> 0x00.
REQ-028 err_ovf SHALL set on any cycle with overflow=1 and clear only on rst; decoding continues while it is set.
REQ-029 evt_valid SHALL never be high on two consecutive cycles.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL take these values:
- nextdata_n=1, evt_valid=0, evt_make=0.
- key_code=0x00, key_ext=0, key_ascii=0x00, key_down=0.
- press_cnt=0, err_ovf=0.
- FSMs at FETCH / P_IDLE.
REQ-031 Reset asserted mid-sequence (e.g. after F0 or during POP) SHALL abandon the partial code, and no pop strobe SHALL issue in the reset cycle.

Structure
REQ-032 A shared package SHALL hold:
- byte constants SC_EXT=0xE0 and SC_BRK=0xF0;
- the handshake-state and parse-state enumerations.
REQ-033 The ASCII lookup SHALL be a combinational sub-module, scancode_to_ascii (8-bit code in, 8-bit ASCII out).

Verification
REQ-034 Bytes 0x1C, 0xF0, 0x1C -> events: make, then break; key_ascii=0x61; press_cnt=1; key_down ends at 0.
REQ-035 Bytes 0x15 ×3, then 0xF0, 0x15 (FILTER_REPEAT=1) -> exactly one make and one break; press_cnt=1; key_ascii=0x71.
REQ-036 Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> make with key_ext=1 and key_ascii=0x00, then break; key_down=0.
REQ-037 ready held high for 6 bytes -> nextdata_n low for exactly 1 cycle per byte, with ≥2 high cycles between strobes.
REQ-038 256 distinct press/release pairs with COUNT_W=8 -> press_cnt wraps to 0x00; an overflow pulse sets err_ovf, which stays high until rst.
REQ-039 rst asserted after byte 0xF0, then 0x23 sent -> 0x23 is treated as a make: key_ascii=0x64, key_down=1.

Source files
------------

// File: rtl/kbd_scan_decoder_pkg.sv
// Shared constants and state encodings for the PS/2 scan-code decoder.
package kbd_scan_decoder_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

   typedef enum logic [1:0] {
      FETCH,
      POP,
      GAP
   } hs_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_BRK,
      P_EXT,
      P_EXT_BRK
   } parse_state_t;

endpackage

// File: rtl/kbd_scan_decoder_ascii.sv
// Scan-code set 2 to lowercase ASCII lookup; letters, digits and space only.
module scancode_to_ascii (
   input  logic [7:0] code,
   output logic [7:0] ascii
);

   always_comb begin
      // NOTE: default first so every path assigns ascii and no latch is inferred.
      ascii = 8'h00;
      case (code)
         8'h1C: ascii = "a";
         8'h32: ascii = "b";
         8'h21: ascii = "c";
         8'h23: ascii = "d";
         8'h24: ascii = "e";
         8'h2B: ascii = "f";
         8'h34: ascii = "g";
         8'h33: ascii = "h";
         8'h43: ascii = "i";
         8'h3B: ascii = "j";
         8'h42: ascii = "k";
         8'h4B: ascii = "l";
         8'h3A: ascii = "m";
         8'h31: ascii = "n";
         8'h44: ascii = "o";
         8'h4D: ascii = "p";
         8'h15: ascii = "q";
         8'h2D: ascii = "r";
         8'h1B: ascii = "s";
         8'h2C: ascii = "t";
         8'h3C: ascii = "u";
         8'h2A: ascii = "v";
         8'h1D: ascii = "w";
         8'h22: ascii = "x";
         8'h35: ascii = "y";
         8'h1A: ascii = "z";
         8'h45: ascii = "0";
         8'h16: ascii = "1";
         8'h1E: ascii = "2";
         8'h26: ascii = "3";
         8'h25: ascii = "4";
         8'h2E: ascii = "5";
         8'h36: ascii = "6";
         8'h3D: ascii = "7";
         8'h3E: ascii = "8";
         8'h46: ascii = "9";
         8'h29: ascii = " ";
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 receiver FIFO drain plus set-2 make/break parser with held-key tracking.
module kbd_scan_decoder #(
   parameter int COUNT_W       = 8,
   parameter bit FILTER_REPEAT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ready,
   input  logic [7:0]         data,
   input  logic               overflow,
   output logic               nextdata_n,
   output logic               evt_valid,
   output logic               evt_make,
   output logic [7:0]         key_code,
   output logic               key_ext,
   output logic [7:0]         key_ascii,
   output logic               key_down,
   output logic [COUNT_W-1:0] press_cnt,
   output logic               err_ovf
);

   import kbd_scan_decoder_pkg::*;

   hs_state_t    hs_state;
   parse_state_t parse_state;
   parse_state_t parse_next;
   logic         take;
   logic         is_make;
   logic         is_break;
   logic         code_ext;
   logic         held_match;
   logic [7:0]   ascii_lut;

   // The parser consumes data on exactly the edge that starts the pop strobe.
   assign take = (hs_state == FETCH) && ready;

   scancode_to_ascii u_ascii (
      .code  (data),
      .ascii (ascii_lut)
   );

   always_comb begin
      parse_next = P_IDLE;
      is_make    = 1'b0;
      is_break   = 1'b0;
      code_ext   = 1'b0;
      case (parse_state)
         P_IDLE: begin
            if (data == SC_EXT)      parse_next = P_EXT;
            else if (data == SC_BRK) parse_next = P_BRK;
            else                     is_make    = 1'b1;
         end
         P_EXT: begin
            code_ext = 1'b1;
            if (data == SC_EXT)      parse_next = P_EXT;
            else if (data == SC_BRK) parse_next = P_EXT_BRK;
            else                     is_make    = 1'b1;
         end
         P_BRK: begin
            if (data == SC_EXT) parse_next = P_EXT;
            else                is_break   = 1'b1;
         end
         P_EXT_BRK: begin
            code_ext = 1'b1;
            if (data == SC_EXT) parse_next = P_EXT;
            else                is_break   = 1'b1;
         end
         default: parse_next = P_IDLE;
      endcase
   end

   assign held_match = key_down && (key_code == data) && (key_ext == code_ext);

   // GAP gives the receiver a cycle to advance its read pointer before resampling.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         hs_state   <= FETCH;
         nextdata_n <= 1'b1;
      end else begin
         case (hs_state)
            FETCH: begin
               if (ready) begin
                  nextdata_n <= 1'b0;
                  hs_state   <= POP;
               end
            end
            POP: begin
               nextdata_n <= 1'b1;
               hs_state   <= GAP;
            end
            GAP:     hs_state <= FETCH;
            default: hs_state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parse_state <= P_IDLE;
         evt_valid   <= 1'b0;
         evt_make    <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_ascii   <= 8'h00;
         key_down    <= 1'b0;
         press_cnt   <= '0;
         err_ovf     <= 1'b0;
      end else begin
         evt_valid <= 1'b0;
         evt_make  <= 1'b0;
         if (overflow) err_ovf <= 1'b1;
         if (take) begin
            parse_state <= parse_next;
            if (is_make && !(FILTER_REPEAT && held_match)) begin
               key_code  <= data;
               key_ext   <= code_ext;
               key_ascii <= code_ext ? 8'h00 : ascii_lut;
               key_down  <= 1'b1;
               evt_valid <= 1'b1;
               evt_make  <= 1'b1;
               press_cnt <= press_cnt + COUNT_W'(1);
            end
            // A break for any key other than the held one is dropped silently.
            if (is_break && held_match) begin
               key_down  <= 1'b0;
               evt_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench: a byte queue stands in for the PS/2 receiver FIFO.
module tb_kbd_scan_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data = 8'h00;
   logic       overflow = 1'b0;
   logic       nextdata_n;
   logic       evt_valid;
   logic       evt_make;
   logic [7:0] key_code;
   logic       key_ext;
   logic [7:0] key_ascii;
   logic       key_down;
   logic [7:0] press_cnt;
   logic       err_ovf;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   int strobes, min_gap, long_low;
   int n_make = 0, n_break = 0, n_consec = 0;
   bit prev_evt = 1'b0;

   kbd_scan_decoder #(.COUNT_W(8), .FILTER_REPEAT(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .data       (data),
      .overflow   (overflow),
      .nextdata_n (nextdata_n),
      .evt_valid  (evt_valid),
      .evt_make   (evt_make),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_ascii  (key_ascii),
      .key_down   (key_down),
      .press_cnt  (press_cnt),
      .err_ovf    (err_ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (evt_valid === 1'b1) begin
         if (prev_evt) n_consec++;
         if (evt_make) n_make++;
         else          n_break++;
      end
      prev_evt = (evt_valid === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      ready = 1'b0;
      overflow = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Feed the queue like a FIFO: the head pops when the strobe is seen low.
   task automatic drain(input int budget);
      int  cyc = 0;
      int  gap = 0;
      bit  prev_low = 1'b0;
      bit  seen = 1'b0;
      strobes = 0;
      min_gap = 1000;
      long_low = 0;
      while (cyc < budget) begin
         if (q.size() > 0) begin
            ready = 1'b1;
            data  = q[0];
         end else begin
            ready = 1'b0;
         end
         @(posedge clk);
         #1 cyc++;
         if (nextdata_n === 1'b0) begin
            if (prev_low) long_low++;
            else begin
               strobes++;
               if (seen && gap < min_gap) min_gap = gap;
               seen = 1'b1;
               if (q.size() > 0) void'(q.pop_front());
            end
            prev_low = 1'b1;
            gap = 0;
         end else begin
            prev_low = 1'b0;
            gap++;
         end
         if (q.size() == 0 && gap >= 4) break;
      end
      ready = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d bytes left, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 8;
      if (nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b want 1", nextdata_n); end
      if (evt_valid !== 1'b0)  begin errors++; $display("FAIL rst_evt_valid: got %b want 0", evt_valid); end
      if (key_code !== 8'h00)  begin errors++; $display("FAIL rst_key_code: got %h want 00", key_code); end
      if (key_ext !== 1'b0)    begin errors++; $display("FAIL rst_key_ext: got %b want 0", key_ext); end
      if (key_ascii !== 8'h00) begin errors++; $display("FAIL rst_key_ascii: got %h want 00", key_ascii); end
      if (key_down !== 1'b0)   begin errors++; $display("FAIL rst_key_down: got %b want 0", key_down); end
      if (press_cnt !== 8'h00) begin errors++; $display("FAIL rst_press_cnt: got %h want 00", press_cnt); end
      if (err_ovf !== 1'b0)    begin errors++; $display("FAIL rst_err_ovf: got %b want 0", err_ovf); end
   endtask

   task automatic test_make_break();
      int m0, b0;
      do_reset();
      m0 = n_make; b0 = n_break;
      q = '{8'h1C};
      drain(40);
      checks += 3;
      if (key_down !== 1'b1)   begin errors++; $display("FAIL mb_down_after_make: got %b want 1", key_down); end
      if (key_ascii !== 8'h61) begin errors++; $display("FAIL mb_ascii: got %h want 61", key_ascii); end
      if (evt_valid !== 1'b0)  begin errors++; $display("FAIL mb_evt_pulse: got %b want 0", evt_valid); end
      q = '{8'hF0, 8'h1C};
      drain(40);
      checks += 5;
      if (n_make - m0 != 1)    begin errors++; $display("FAIL mb_makes: got %0d want 1", n_make - m0); end
      if (n_break - b0 != 1)   begin errors++; $display("FAIL mb_breaks: got %0d want 1", n_break - b0); end
      if (press_cnt !== 8'h01) begin errors++; $display("FAIL mb_cnt: got %h want 01", press_cnt); end
      if (key_down !== 1'b0)   begin errors++; $display("FAIL mb_down_end: got %b want 0", key_down); end
      if (key_code !== 8'h1C)  begin errors++; $display("FAIL mb_code_held: got %h want 1c", key_code); end
   endtask

   task automatic test_repeat_filter();
      int m0, b0;
      do_reset();
      m0 = n_make; b0 = n_break;
      q = '{8'h15, 8'h15, 8'h15, 8'hF0, 8'h15};
      drain(80);
      checks += 5;
      if (n_make - m0 != 1)    begin errors++; $display("FAIL rep_makes: got %0d want 1", n_make - m0); end
      if (n_break - b0 != 1)   begin errors++; $display("FAIL rep_breaks: got %0d want 1", n_break - b0); end
      if (press_cnt !== 8'h01) begin errors++; $display("FAIL rep_cnt: got %h want 01", press_cnt); end
      if (key_ascii !== 8'h71) begin errors++; $display("FAIL rep_ascii: got %h want 71", key_ascii); end
      if (key_down !== 1'b0)   begin errors++; $display("FAIL rep_down: got %b want 0", key_down); end
   endtask

   task automatic test_extended();
      int m0, b0;
      do_reset();
      m0 = n_make; b0 = n_break;
      q = '{8'hE0, 8'h75};
      drain(40);
      checks += 5;
      if (n_make - m0 != 1)    begin errors++; $display("FAIL ext_makes: got %0d want 1", n_make - m0); end
      if (key_ext !== 1'b1)    begin errors++; $display("FAIL ext_flag: got %b want 1", key_ext); end
      if (key_ascii !== 8'h00) begin errors++; $display("FAIL ext_ascii: got %h want 00", key_ascii); end
      if (key_code !== 8'h75)  begin errors++; $display("FAIL ext_code: got %h want 75", key_code); end
      if (key_down !== 1'b1)   begin errors++; $display("FAIL ext_down: got %b want 1", key_down); end
      // A plain break of the same code must not release the extended key.
      q = '{8'hF0, 8'h75};
      drain(40);
      checks++;
      if (key_down !== 1'b1)   begin errors++; $display("FAIL ext_plain_break: got %b want 1", key_down); end
      q = '{8'hE0, 8'hF0, 8'h75};
      drain(40);
      checks += 2;
      if (n_break - b0 != 1)   begin errors++; $display("FAIL ext_breaks: got %0d want 1", n_break - b0); end
      if (key_down !== 1'b0)   begin errors++; $display("FAIL ext_down_end: got %b want 0", key_down); end
   endtask

   task automatic test_nonmatch_break();
      int b0;
      do_reset();
      q = '{8'h1C, 8'hF0, 8'h32, 8'hE0, 8'hF0, 8'h1C};
      b0 = n_break;
      drain(80);
      checks += 3;
      if (n_break - b0 != 0)  begin errors++; $display("FAIL nm_breaks: got %0d want 0", n_break - b0); end
      if (key_down !== 1'b1)  begin errors++; $display("FAIL nm_down: got %b want 1", key_down); end
      if (key_code !== 8'h1C) begin errors++; $display("FAIL nm_code: got %h want 1c", key_code); end
      // An E0 after F0 restarts an extended sequence and discards the break.
      q = '{8'hF0, 8'hE0, 8'h1C};
      drain(60);
      checks += 2;
      if (key_ext !== 1'b1)   begin errors++; $display("FAIL nm_e0_restart_ext: got %b want 1", key_ext); end
      if (press_cnt !== 8'h02) begin errors++; $display("FAIL nm_e0_restart_cnt: got %h want 02", press_cnt); end
   endtask

   task automatic test_back_to_back();
      int m0, b0;
      do_reset();
      m0 = n_make; b0 = n_break;
      q = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32};
      drain(80);
      checks += 6;
      if (strobes != 6)       begin errors++; $display("FAIL b2b_strobes: got %0d want 6", strobes); end
      if (long_low != 0)      begin errors++; $display("FAIL b2b_low_width: extra low cycles %0d want 0", long_low); end
      if (min_gap < 2)        begin errors++; $display("FAIL b2b_gap: got %0d want >=2", min_gap); end
      if (n_make - m0 != 2)   begin errors++; $display("FAIL b2b_makes: got %0d want 2", n_make - m0); end
      if (n_break - b0 != 2)  begin errors++; $display("FAIL b2b_breaks: got %0d want 2", n_break - b0); end
      if (n_consec != 0)      begin errors++; $display("FAIL b2b_evt_consec: got %0d want 0", n_consec); end
   endtask

   task automatic test_wrap_overflow();
      logic [7:0] code;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         code = 8'(1 + (i % 200));
         q = '{code, 8'hF0, code};
         drain(60);
         if (i == 254) begin
            checks++;
            if (press_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h want ff", press_cnt); end
         end
      end
      checks += 2;
      if (press_cnt !== 8'h00) begin errors++; $display("FAIL wrap_00: got %h want 00", press_cnt); end
      if (key_down !== 1'b0)   begin errors++; $display("FAIL wrap_down: got %b want 0", key_down); end
      @(posedge clk);
      #1 overflow = 1'b1;
      @(posedge clk);
      #1 overflow = 1'b0;
      checks++;
      if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
      q = '{8'h1C};
      drain(40);
      checks += 2;
      if (err_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
      if (press_cnt !== 8'h01) begin errors++; $display("FAIL ovf_decode_on: got %h want 01", press_cnt); end
      do_reset();
      checks++;
      if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
   endtask

   task automatic test_reset_mid();
      int m0;
      int low_seen = 0;
      do_reset();
      data = 8'h1C;
      ready = 1'b1;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1 if (nextdata_n !== 1'b1) low_seen++;
      end
      ready = 1'b0;
      rst = 1'b0;
      checks++;
      if (low_seen != 0) begin errors++; $display("FAIL rstmid_no_strobe: low cycles %0d want 0", low_seen); end
      q = '{8'hF0};
      drain(40);
      do_reset();
      m0 = n_make;
      q = '{8'h23};
      drain(40);
      checks += 4;
      if (n_make - m0 != 1)    begin errors++; $display("FAIL rstmid_make: got %0d want 1", n_make - m0); end
      if (key_ascii !== 8'h64) begin errors++; $display("FAIL rstmid_ascii: got %h want 64", key_ascii); end
      if (key_down !== 1'b1)   begin errors++; $display("FAIL rstmid_down: got %b want 1", key_down); end
      if (press_cnt !== 8'h01) begin errors++; $display("FAIL rstmid_cnt: got %h want 01", press_cnt); end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_repeat_filter();
      test_extended();
      test_nonmatch_break();
      test_back_to_back();
      test_wrap_overflow();
      test_reset_mid();
      checks++;
      if (n_consec != 0) begin errors++; $display("FAIL evt_consec_total: got %0d want 0", n_consec); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
